mul_partial_combine: RTL and testbench
======================================

Name: mul_partial_combine

Overview:
- Downstream stage of the CPU multiplier cell.
- Takes the three registered 16x16 partial products (lo*lo, lo_a*hi_b, hi_a*lo_b) and sums them into the low 32 bits of the 32x32 product.
- 2-stage pipeline with valid/ready handshake, destination-tag passthrough, pipeline flush and a completed-operation counter.
- Feeds the M/W-stage result mux and the writeback path.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each operation.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  partial-product set present.
- in_ready  out  1  stage can accept this cycle.
- in_p1  in  32  src1[15:0]*src2[15:0].
- in_p2  in  32  src1[15:0]*src2[31:16].
- in_p3  in  32  src1[31:16]*src2[15:0].
- in_tag  in  TAG_W  destination tag.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  low 32 bits of product.
- out_tag  out  TAG_W  tag of out_result.
- op_count  out  CNT_W  count of results handed off.

Behaviour:
- Reset (sync, active-high, checked at the clock edge):
  - s1_valid, s2_valid, out_result, out_tag, op_count all 0.
  - in_ready is 0 while reset is high and 1 on the first cycle after reset deasserts.
- Stage 1 register, loaded on accept:
  - s1_p1 = in_p1.
  - s1_cross = (in_p2[15:0] + in_p3[15:0]) mod 2^16; upper bits of p2/p3 are ignored.
  - s1_tag = in_tag.
- Stage 2 register:
  - out_result = (s1_p1 + {s1_cross, 16'h0000}) mod 2^32.
  - out_tag = s1_tag.
  - out_valid = s2_valid.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !reset && !flush && (!s1_valid || !s2_valid || out_ready).
  - Accept occurs when in_valid && in_ready.
  - s1_valid next = s1_load || (s1_valid && !s2_load).
  - s2_valid next = s2_load || (s2_valid && !out_ready).
- Latency and throughput:
  - Accept at cycle N gives out_valid at cycle N+2 when there is no backpressure.
  - Sustained throughput is 1 op/cycle.
  - Results leave in acceptance order.
- Backpressure:
  - While out_valid && !out_ready, out_result and out_tag hold stable.
  - s1 holds if s2 cannot load.
  - in_ready falls only when both stages are full and out_ready=0.
  - No op is lost or duplicated.
- Simultaneous hand-off and accept: with out_ready=1 and both stages full, s2 drains, s1 moves to s2 and a new op enters s1 in the same cycle.
- flush:
  - At the edge where flush=1, s1_valid and s2_valid clear.
  - in_ready=0 that cycle, so no accept.
  - A pending out_valid in that cycle does not count even if out_ready=1.
  - Data registers may keep stale values; only the valids matter.
- op_count:
  - Increments by 1 on out_valid && out_ready && !flush.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset.
- reset mid-operation: all in-flight ops are discarded and out_valid is 0 the next cycle. Reset has priority over flush.
- out_result and out_tag are don't-care while out_valid=0, except after reset, when they are 0.

Test Plan:
1. Basic: p1=0x00000008, p2=0x0000000A, p3=0x0000000C, tag=3, out_ready=1 -> two cycles later out_valid=1, out_result=0x00160008, out_tag=3, op_count=1. This is 0x00030002*0x00050004.
2. Wrap: p1=0xFFFF0001, p2=0x00000001, p3=0x00000000 -> out_result=0x00000001. Then p1=0xFFFFFFFF, p2=0xABCDFFFF, p3=0x12340001 -> cross=0x0000, out_result=0xFFFFFFFF.
3. Backpressure: stream tags 1..4 back-to-back, out_ready=0 for 4 cycles after the first out_valid:
   - in_ready drops once s1 and s2 are full.
   - Results emerge as tags 1,2,3,4 with correct values and no gaps or duplicates once out_ready=1.
   - op_count=4.
4. Flush: accept tags 5 and 6 on consecutive cycles, assert flush one cycle later for one cycle -> out_valid never asserts for 5 or 6, op_count unchanged, in_ready=0 during the flush cycle and 1 after it.
5. Reset mid-op: two ops in flight with out_valid=1 and out_ready=0, assert reset one cycle -> next cycle out_valid=0, out_result=0, out_tag=0, op_count=0, in_ready=1 after deassert.
6. Counter wrap: preload by streaming 65535 ops, then one more -> op_count goes 0xFFFF then 0x0000.

Source files
------------

// File: rtl/mul_partial_combine.sv
// Final combine stage of the multiplier cell. It folds the three 16x16 partial
// products into the low 32 bits of the 32x32 product through a 2-stage valid/ready pipeline.
module mul_partial_combine #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_reg;
  logic [31:0]      s1_p1_reg;
  logic [15:0]      s1_cross_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg;
  logic [31:0]      result_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [CNT_W-1:0] count_reg;

  logic             s1_load;
  logic             s2_load;
  logic             handoff;
  logic [15:0]      cross_next;
  logic [31:0]      result_next;

  // The upper halves of the cross products only reach bits 32 and above, so they are dropped.
  logic             unused_hi;
  assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

  assign in_ready    = !reset && !flush && (!s1_valid_reg || !s2_valid_reg || out_ready);
  assign s1_load     = in_valid && in_ready;
  assign s2_load     = s1_valid_reg && (!s2_valid_reg || out_ready);
  assign handoff     = s2_valid_reg && out_ready && !flush;
  assign cross_next  = in_p2[15:0] + in_p3[15:0];
  assign result_next = s1_p1_reg + {s1_cross_reg, 16'h0000};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_p1_reg    <= '0;
      s1_cross_reg <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
      tag_reg      <= '0;
      count_reg    <= '0;
    end else begin
      // Flush only kills the valids; the data registers may keep stale contents.
      if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        s1_valid_reg <= s1_load || (s1_valid_reg && !s2_load);
        s2_valid_reg <= s2_load || (s2_valid_reg && !out_ready);
      end
      if (s1_load) begin
        s1_p1_reg    <= in_p1;
        s1_cross_reg <= cross_next;
        s1_tag_reg   <= in_tag;
      end
      if (s2_load) begin
        result_reg <= result_next;
        tag_reg    <= s1_tag_reg;
      end
      if (handoff) begin
        count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_result = result_reg;
  assign out_tag    = tag_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_mul_partial_combine.sv
// Scoreboard bench for mul_partial_combine. Directed stimulus pushes expected
// results into a queue, and a negedge monitor checks every result handed off.
`timescale 1ns/1ps
module tb_mul_partial_combine;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p1, in_p2, in_p3;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [15:0] op_count;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          verbose = 1'b1;
  logic [36:0] exp_q[$];
  bit          stall_prev = 1'b0;
  logic [31:0] held_result;
  logic [4:0]  held_tag;

  mul_partial_combine #(.TAG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] p1, input logic [31:0] p2,
                                        input logic [31:0] p3);
    logic [15:0] c;
    c = p2[15:0] + p3[15:0];
    return p1 + {c, 16'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                      input logic [4:0] tag, input logic [31:0] exp, input bit push);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_p1 = p1;
    in_p2 = p2;
    in_p3 = p3;
    in_tag = tag;
    while (!done && k < 64) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (push) exp_q.push_back({tag, exp});
        if (verbose) $display("send tag=%0d p1=0x%08h p2=0x%08h p3=0x%08h expect=0x%08h tracked=%0d",
                              tag, p1, p2, p3, exp, push);
      end
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: results compared in acceptance order, and held stable under backpressure.
  always @(negedge clk) begin
    logic [36:0] e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("hold_result", out_result, held_result);
        check("hold_tag", 32'(out_tag), 32'(held_tag));
      end
      stall_prev  = out_valid && !out_ready && !flush;
      held_result = out_result;
      held_tag    = out_tag;
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          if (verbose) $display("recv tag=%0d result=0x%08h expect tag=%0d result=0x%08h",
                                out_tag, out_result, e[36:32], e[31:0]);
          check("result", out_result, e[31:0]);
          check("tag", 32'(out_tag), 32'(e[36:32]));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Basic op and two-cycle latency
    send(32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 5'd3, 32'h0016_0008, 1'b1);
    @(negedge clk);
    check("lat_n1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_out_valid", 32'(out_valid), 32'd1);
    check("lat_n2_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    check("basic_op_count", 32'(op_count), 32'd1);
    check("basic_out_valid_low", 32'(out_valid), 32'd0);
    tick();

    // Modular wrap of the sum and of the cross term
    send(32'hFFFF_0001, 32'h0000_0001, 32'h0000_0000, 5'd7, 32'h0000_0001, 1'b1);
    send(32'hFFFF_FFFF, 32'hABCD_FFFF, 32'h1234_0001, 5'd8, 32'hFFFF_FFFF, 1'b1);
    wait_drain(20);
    check("wrap_op_count", 32'(op_count), 32'd3);
    tick();

    // Backpressure: four back-to-back ops, output stalled for four cycles
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'd1, 32'h0005_0001, 1'b1);
        send(32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 5'd2, 32'h0050_0010, 1'b1);
        send(32'h1234_5678, 32'h0000_1111, 32'h0000_2222, 5'd3, 32'h4567_5678, 1'b1);
        send(32'h8000_0000, 32'hFFFF_8000, 32'h0000_8000, 5'd4, 32'h8000_0000, 1'b1);
      end
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!out_valid && k < 50);
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(40);
    check("bp_op_count", 32'(op_count), 32'd7);
    check("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();

    // Flush kills two in-flight ops; the pending result does not count
    send(32'h0000_0005, 32'h0000_0005, 32'h0000_0005, 5'd5, 32'h0, 1'b0);
    send(32'h0000_0006, 32'h0000_0006, 32'h0000_0006, 5'd6, 32'h0, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_tag = 5'd9;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    check("flush_op_count", 32'(op_count), 32'd7);
    repeat (3) @(negedge clk);
    check("flush_out_valid_later", 32'(out_valid), 32'd0);
    check("flush_op_count_later", 32'(op_count), 32'd7);
    tick();

    // Reset while two ops are in flight and the output is stalled
    out_ready = 1'b0;
    send(32'h0000_00AA, 32'h0000_0001, 32'h0000_0001, 5'd10, 32'h0, 1'b0);
    send(32'h0000_00BB, 32'h0000_0002, 32'h0000_0002, 5'd11, 32'h0, 1'b0);
    @(negedge clk);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Counter wrap: 65535 ops, then one more
    verbose = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      logic [31:0] a, b, c;
      a = 32'(i) * 32'h0000_9E37;
      b = 32'(i);
      c = 32'(i) << 3;
      send(a, b, c, 5'(i), model(a, b, c), 1'b1);
    end
    wait_drain(50);
    check("cnt_full", 32'(op_count), 32'h0000_FFFF);
    tick();
    verbose = 1'b1;
    send(32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 5'd31, 32'h0007_0002, 1'b1);
    wait_drain(20);
    check("cnt_wrap", 32'(op_count), 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
